// File: rtl/shifter_arbiter.sv
// Round-robin arbiter that shares one logical-left shifter among NREQ requesters
// and holds each result in a one-entry registered response slot.

module shl_unit #(
  parameter int N  = 32,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  operand,
  input  logic [SW-1:0] shamt,
  output logic [N-1:0]  result
);
  assign result = operand << shamt;
endmodule

module shifter_arbiter #(
  parameter int N    = 32,
  parameter int NREQ = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*N-1:0]          req_data,
  input  logic [NREQ*$clog2(N)-1:0]  req_shamt,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [N-1:0]               rsp_data,
  output logic [$clog2(NREQ)-1:0]    rsp_id
);
  localparam int SW   = $clog2(N);
  localparam int ID_W = $clog2(NREQ);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high. req_ready is a function of req_valid, ptr, state and rsp_ready;
  // requesters must not make req_valid depend on req_ready.

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e          state, state_nxt;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] scan_idx;
  logic            gnt_valid;
  logic            slot_free;
  logic            accept;
  logic [N-1:0]    sel_data;
  logic [SW-1:0]   sel_shamt;
  logic [N-1:0]    shift_out;

  // First valid requester at or after ptr, wrapping; NREQ is a power of two.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = ptr + ID_W'(k);
      if (!gnt_valid && req_valid[scan_idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  assign slot_free = (state == EMPTY) | (rsp_valid & rsp_ready);
  assign accept    = slot_free & gnt_valid;
  assign sel_data  = req_data[gnt_idx*N +: N];
  assign sel_shamt = req_shamt[gnt_idx*SW +: SW];

  shl_unit #(.N(N), .SW(SW)) u_shl (
    .operand (sel_data),
    .shamt   (sel_shamt),
    .result  (shift_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept)                              state_nxt = FULL;
    else if (state == FULL && rsp_ready)     state_nxt = EMPTY;
  end

  // req_ready is forced low during reset even though the slot reads as free.
  always_comb begin
    rsp_valid = (state == FULL);
    req_ready = '0;
    if (rst_n && accept) req_ready[gnt_idx] = 1'b1;
  end

  // Result, owner and priority pointer only move on an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
      rsp_id   <= '0;
      ptr      <= '0;
    end else if (accept) begin
      rsp_data <= shift_out;
      rsp_id   <= gnt_idx;
      ptr      <= gnt_idx + ID_W'(1);
    end
  end
endmodule

// File: tb/tb_shifter_arbiter.sv
// Self-checking bench for shifter_arbiter: directed table, corner sequences and
// a randomized run against a queue-based reference model.

module tb_shifter_arbiter;
  localparam int N    = 32;
  localparam int NREQ = 4;
  localparam int SW   = 5;
  localparam int W    = 2 + N;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*N-1:0]      req_data;
  logic [NREQ*SW-1:0]     req_shamt;
  logic                   rsp_valid;
  logic                   rsp_ready = 1'b0;
  logic [N-1:0]           rsp_data;
  logic [1:0]             rsp_id;

  logic [N-1:0]  d [NREQ];
  logic [SW-1:0] s [NREQ];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_data[i*N +: N]    = d[i];
      req_shamt[i*SW +: SW] = s[i];
    end
  end

  shifter_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_shamt (req_shamt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    int          id;
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];
  logic [W-1:0] exp_q [$];
  logic [NREQ-1:0] pend;

  initial begin
    for (int i = 0; i < NREQ; i++) begin d[i] = '0; s[i] = '0; end

    vecs[0] = '{0, 32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFF};
    vecs[1] = '{1, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE};
    vecs[2] = '{2, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000};
    vecs[3] = '{3, 32'h0000_0001, 5'd31, 32'h8000_0000};
    vecs[4] = '{0, 32'h1234_5678, 5'd4,  32'h2345_6780};
    vecs[5] = '{2, 32'hA5A5_A5A5, 5'd16, 32'hA5A5_0000};
    vecs[6] = '{1, 32'h8000_0001, 5'd1,  32'h0000_0002};
    vecs[7] = '{3, 32'hFFFF_FFFE, 5'd31, 32'h0000_0000};

    // Reset values, with all requesters asking
    req_valid = 4'b1111;
    repeat (2) @(negedge clk);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_rsp_id", rsp_id, 0);
    check("reset_req_ready", req_ready, 0);
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;

    // Single op
    d[0] = 32'h1; s[0] = 5'd4; req_valid = 4'b0001; rsp_ready = 1'b1;
    #1 check("single_req_ready", req_ready, 4'b0001);
    @(posedge clk); #1;
    check("single_rsp_valid", rsp_valid, 1);
    check("single_rsp_data", rsp_data, 32'h10);
    check("single_rsp_id", rsp_id, 0);
    @(negedge clk); req_valid = '0;

    // Round-robin with all valid
    do_reset();
    for (int i = 0; i < NREQ; i++) begin d[i] = 32'h1; s[i] = SW'(i); end
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("rr_rsp_valid", rsp_valid, 1);
      check("rr_rsp_id", rsp_id, k % 4);
      check("rr_rsp_data", rsp_data, 32'h1 << (k % 4));
    end

    // Backpressure with id 2 holding 0xFF00
    @(negedge clk);
    req_valid = 4'b0100; d[2] = 32'hFF; s[2] = 5'd8;
    @(posedge clk); #1;
    check("bp_fill_id", rsp_id, 2);
    @(negedge clk);
    req_valid = 4'b1111; d[2] = 32'h1; s[2] = 5'd2; rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1 check("bp_req_ready", req_ready, 0);
      @(posedge clk); #1;
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_data", rsp_data, 32'h0000_FF00);
      check("bp_rsp_id", rsp_id, 2);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1 check("bp_release_ready", req_ready, 4'b1000);
    @(posedge clk); #1;
    check("bp_release_id", rsp_id, 3);
    check("bp_release_data", rsp_data, 32'h8);
    @(negedge clk); req_valid = '0;
    @(negedge clk);

    // Shift vector table, back-to-back
    for (int v = 0; v < 8; v++) begin
      d[vecs[v].id] = vecs[v].data;
      s[vecs[v].id] = vecs[v].shamt;
      req_valid = 4'b0001 << vecs[v].id;
      #1 check("vec_req_ready", req_ready, 4'b0001 << vecs[v].id);
      @(posedge clk); #1;
      check("vec_rsp_valid", rsp_valid, 1);
      check("vec_rsp_data", rsp_data, vecs[v].exp);
      check("vec_rsp_id", rsp_id, vecs[v].id);
      @(negedge clk);
    end
    req_valid = '0;

    // Priority wrap after idle
    @(negedge clk);
    req_valid = 4'b1000;
    @(posedge clk); #1 check("wrap_first_id", rsp_id, 3);
    @(negedge clk); req_valid = '0;
    repeat (4) @(negedge clk);
    check("wrap_idle_valid", rsp_valid, 0);
    req_valid = 4'b1001;
    #1 check("wrap_ready0", req_ready, 4'b0001);
    @(posedge clk); #1 check("wrap_id0", rsp_id, 0);
    @(negedge clk);
    #1 check("wrap_ready3", req_ready, 4'b1000);
    @(posedge clk); #1 check("wrap_id3", rsp_id, 3);
    @(negedge clk); req_valid = '0;

    // Async reset while FULL
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = 4'b1111; rsp_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("areset_rsp_valid", rsp_valid, 0);
    check("areset_req_ready", req_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; req_valid = 4'b0110; rsp_ready = 1'b1;
    #1 check("areset_ready1", req_ready, 4'b0010);
    @(posedge clk); #1 check("areset_id1", rsp_id, 1);
    @(negedge clk); req_valid = '0;

    // Randomized run against the reference model
    do_reset();
    pend = '0;
    begin
      int m_ptr;
      m_ptr = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
        bit full, free;
        int g;
        logic [N-1:0] res;
        logic [1:0] gid;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
          if (!pend[i] && $urandom_range(0, 1) == 1) begin
            pend[i] = 1'b1;
            d[i] = $urandom;
            s[i] = SW'($urandom_range(0, 31));
          end
        end
        req_valid = pend;
        rsp_ready = ($urandom_range(0, 3) != 0);
        #1;
        full = (exp_q.size() != 0);
        check("rnd_rsp_valid", rsp_valid, full);
        if (full) check("rnd_rsp", {rsp_id, rsp_data}, exp_q[0]);
        free = !full || rsp_ready;
        g = -1;
        for (int k = 0; k < NREQ; k++)
          if (g < 0 && pend[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
        check("rnd_req_ready", req_ready, (free && g >= 0) ? (64'h1 << g) : 64'h0);
        if (full && rsp_ready) void'(exp_q.pop_front());
        if (free && g >= 0) begin
          res = d[g] << s[g];
          gid = g[1:0];
          exp_q.push_back({gid, res});
          pend[g] = 1'b0;
          m_ptr = (g + 1) % NREQ;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
